// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous BRAM between the
// core memory port (c_*) and the loader/debug port (l_*).
// Ports: clk/reset (async, active-high); c_* core request/grant/read return;
// l_* loader request/grant/read return plus l_lock for bounded burst
// ownership; mem_* memory interface (1-cycle read latency); lock_active.
module mem_port_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_adr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_adr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_lock,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic [AW-1:0] mem_adr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          lock_active
);

  localparam int unsigned CW = $clog2(LOCK_MAX) + 1;

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_LOCK = 2'd1,
    ST_COOL = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          last_l_q, last_l_d;   // 1: loader was the last owner
  logic          rd_pend_q, rd_pend_d;
  logic          rd_src_q, rd_src_d;   // 1: pending read belongs to loader

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ARB;
      lock_cnt_q <= '0;
      last_l_q   <= 1'b1;
      rd_pend_q  <= 1'b0;
      rd_src_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      last_l_q   <= last_l_d;
      rd_pend_q  <= rd_pend_d;
      rd_src_q   <= rd_src_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_l_d   = last_l_q;
    c_gnt      = 1'b0;
    l_gnt      = 1'b0;

    unique case (state_q)
      ST_ARB: begin
        if (c_req && l_req) begin
          c_gnt = last_l_q;
          l_gnt = !last_l_q;
        end else begin
          c_gnt = c_req;
          l_gnt = l_req;
        end
        if (l_gnt && l_lock) begin
          state_d    = ST_LOCK;
          lock_cnt_d = '0;
        end
      end
      ST_LOCK: begin
        l_gnt      = l_req;
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (!l_lock || (lock_cnt_q == CW'(LOCK_MAX - 1))) begin
          state_d = ST_COOL;
        end
      end
      ST_COOL: begin
        c_gnt   = c_req;
        l_gnt   = !c_req && l_req;
        state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase

    // Grants are suppressed while reset is held; state flops are held anyway.
    if (reset) begin
      c_gnt = 1'b0;
      l_gnt = 1'b0;
    end

    if (c_gnt || l_gnt) begin
      last_l_d = l_gnt;
    end
  end

  always_comb begin
    rd_pend_d = (c_gnt && !c_we) || (l_gnt && !l_we);
    rd_src_d  = rd_pend_d ? l_gnt : rd_src_q;
  end

  always_comb begin
    mem_adr     = l_gnt ? l_adr : c_adr;
    mem_wdata   = l_gnt ? l_wdata : c_wdata;
    mem_we      = (c_gnt && c_we) || (l_gnt && l_we);
    c_rvalid    = rd_pend_q && !rd_src_q;
    l_rvalid    = rd_pend_q && rd_src_q;
    c_rdata     = mem_rdata;
    l_rdata     = mem_rdata;
    lock_active = (state_q == ST_LOCK);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned LOCK_MAX = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          c_req = 1'b0, c_we = 1'b0;
  logic [AW-1:0] c_adr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic          c_gnt, c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [AW-1:0] l_adr = '0;
  logic [DW-1:0] l_wdata = '0;
  logic          l_gnt, l_rvalid;
  logic [DW-1:0] l_rdata;
  logic [AW-1:0] mem_adr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          lock_active;
  logic          preload = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(rst),
    .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_adr(l_adr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_adr(mem_adr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .lock_active(lock_active)
  );

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
  endfunction

  // Synchronous BRAM, 256 words, word address taken from adr[9:2].
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (preload) begin
      for (int unsigned i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else begin
      if (mem_we) mem[mem_adr[9:2]] <= mem_wdata;
      mem_rdata <= mem[mem_adr[9:2]];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: arbitration by rule (who is waiting, who went last,
  // how long the loader has held the lock), plus a shadow of memory contents.
  int          m_mode;   // 0 arbitrate, 1 locked, 2 cool-down
  bit          m_last_l;
  int          m_cnt;
  bit          m_pend, m_src;
  logic [31:0] m_pdata;
  logic [31:0] smem [256];
  bit          m_gc, m_gl;
  logic        obs_c, obs_l, obs_lock, obs_we, obs_cv, obs_lv;
  logic [31:0] obs_adr;

  task automatic cycle();
    bit gc, gl, we_e;
    logic [31:0] adr_e, wd_e;
    int idx;
    @(negedge clk);
    gc = 0; gl = 0;
    if (!rst) begin
      if (m_mode == 1) begin
        gl = l_req;
      end else if (m_mode == 2) begin
        gc = c_req;
        gl = !c_req && l_req;
      end else if (c_req && l_req) begin
        gc = m_last_l;    // the one who did not go last wins
        gl = !m_last_l;
      end else begin
        gc = c_req;
        gl = l_req;
      end
    end
    we_e  = (gc && c_we) || (gl && l_we);
    adr_e = gl ? l_adr : c_adr;
    wd_e  = gl ? l_wdata : c_wdata;
    check("c_gnt", c_gnt, gc);
    check("l_gnt", l_gnt, gl);
    check("mem_adr", mem_adr, adr_e);
    check("mem_we", mem_we, we_e);
    if (we_e) check("mem_wdata", mem_wdata, wd_e);
    check("c_rvalid", c_rvalid, !rst && m_pend && !m_src);
    check("l_rvalid", l_rvalid, !rst && m_pend && m_src);
    if (!rst && m_pend) check("rdata", m_src ? l_rdata : c_rdata, m_pdata);
    check("lock_active", lock_active, !rst && m_mode == 1);
    obs_c = c_gnt; obs_l = l_gnt; obs_lock = lock_active; obs_we = mem_we;
    obs_cv = c_rvalid; obs_lv = l_rvalid; obs_adr = mem_adr;

    if (rst) begin
      m_mode = 0; m_last_l = 1; m_cnt = 0; m_pend = 0;
    end else begin
      idx    = int'(adr_e[9:2]);
      m_pend = (gc && !c_we) || (gl && !l_we);
      m_src  = gl;
      m_pdata = smem[idx];
      if (we_e) smem[idx] = wd_e;
      if (gc || gl) m_last_l = gl;
      if (m_mode == 0) begin
        if (gl && l_lock) begin m_mode = 1; m_cnt = 0; end
      end else if (m_mode == 1) begin
        if (!l_lock || m_cnt == LOCK_MAX - 1) m_mode = 2;
        m_cnt++;
      end else begin
        m_mode = 0;
      end
    end
    m_gc = gc; m_gl = gl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    c_req = 0; l_req = 0; l_lock = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int run, sum_l, sum_c, sum_lk, lock_pct;
    bit seen, done;
    logic cool_c;
    logic [3:0] seq;

    for (int unsigned i = 0; i < 256; i++) smem[i] = init_word(i);
    m_mode = 0; m_last_l = 1; m_cnt = 0; m_pend = 0; m_src = 0; m_pdata = '0;

    // Reset state, with both requests asserted to show grants are held off.
    repeat (3) @(posedge clk);
    #1;
    c_req = 1; l_req = 1;
    cycle();
    preload = 0;
    rst = 0;
    c_req = 0; l_req = 0;

    // 1: core-only read
    c_req = 1; c_we = 0; c_adr = 32'h10;
    cycle();
    check("t1_gnt", obs_c, 1);
    check("t1_adr", obs_adr, 32'h10);
    check("t1_c_rvalid", c_rvalid, 1);
    check("t1_c_rdata", c_rdata, 32'hDEADBEEF);
    check("t1_l_rvalid", l_rvalid, 0);
    idle(1);

    // 2: contention right after reset: core, loader, core, loader
    rst = 1; cycle(); rst = 0;
    c_req = 1; c_we = 0; c_adr = 32'h14;
    l_req = 1; l_we = 0; l_adr = 32'h18;
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      seq = {seq[2:0], obs_l};
      check("t2_adr", obs_adr, obs_l ? 32'h18 : 32'h14);
    end
    check("t2_seq", seq, 4'b0101);
    idle(2);

    // 3: locked burst of three loader writes against a waiting core
    c_req = 1; c_we = 0; c_adr = 32'h30;
    cycle();
    c_adr = 32'h34;
    l_req = 1; l_we = 1; l_adr = 32'h100; l_wdata = 32'h1; l_lock = 1;
    sum_l = 0; sum_c = 0; sum_lk = 0;
    cycle(); sum_l += int'(obs_l); sum_c += int'(obs_c);
    l_adr = 32'h104; l_wdata = 32'h2;
    cycle(); sum_l += int'(obs_l); sum_c += int'(obs_c); sum_lk += int'(obs_lock);
    l_adr = 32'h108; l_wdata = 32'h3; l_lock = 0;
    cycle(); sum_l += int'(obs_l); sum_c += int'(obs_c); sum_lk += int'(obs_lock);
    check("t3_l_gnts", sum_l, 3);
    check("t3_c_gnts", sum_c, 0);
    check("t3_lock_cycles", sum_lk, 2);
    l_req = 0;
    cycle();
    check("t3_cool_core", obs_c, 1);
    l_req = 1; l_we = 0; l_adr = 32'h104;
    cycle();
    check("t3_rr_loader", obs_l, 1);
    idle(2);

    // 4: lock timeout with the lock held forever
    c_req = 1; c_we = 0; c_adr = 32'h60;
    l_req = 1; l_we = 1; l_adr = 32'h200; l_wdata = 32'h77; l_lock = 1;
    run = 0; seen = 0; done = 0; cool_c = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      cycle();
      if (obs_lock) begin
        seen = 1; run++;
      end else if (seen) begin
        done = 1; cool_c = obs_c;
      end
    end
    check("t4_lock_len", run, LOCK_MAX);
    check("t4_cool_core", cool_c, 1);
    check("t4_no_relock", lock_active, 0);
    idle(2);

    // 5: core read, core write, loader read back to back
    c_req = 1; c_we = 0; c_adr = 32'h20;
    cycle();
    check("t5_we1", obs_we, 0);
    c_we = 1; c_adr = 32'h24; c_wdata = 32'h55;
    cycle();
    check("t5_we2", obs_we, 1);
    check("t5_cv2", obs_cv, 1);
    c_req = 0; l_req = 1; l_we = 0; l_adr = 32'h28;
    cycle();
    check("t5_gnt3", obs_l, 1);
    check("t5_we3", obs_we, 0);
    check("t5_cv3", obs_cv, 0);
    l_req = 0;
    cycle();
    check("t5_lv4", obs_lv, 1);
    check("t5_cv4", obs_cv, 0);
    idle(1);

    // 6: reset in LOCK with a loader read pending
    l_req = 1; l_we = 0; l_adr = 32'h40; l_lock = 1;
    cycle();
    l_adr = 32'h44;
    cycle();
    rst = 1;
    #1;
    check("t6_c_gnt", c_gnt, 0);
    check("t6_l_gnt", l_gnt, 0);
    check("t6_l_rvalid", l_rvalid, 0);
    check("t6_c_rvalid", c_rvalid, 0);
    check("t6_mem_we", mem_we, 0);
    check("t6_lock", lock_active, 0);
    cycle();
    rst = 0;
    c_req = 1; c_we = 0; c_adr = 32'h50; l_lock = 0;
    cycle();
    check("t6_core_first", obs_c, 1);
    idle(2);

    // Randomised traffic against the model
    for (int seg = 0; seg < 20; seg++) begin
      case ($urandom_range(0, 2))
        0:       lock_pct = 0;
        1:       lock_pct = 40;
        default: lock_pct = 97;
      endcase
      for (int i = 0; i < 100; i++) begin
        rst = ($urandom_range(0, 149) == 0);
        if (!c_req || m_gc) begin
          c_req   = ($urandom_range(0, 2) != 0);
          c_we    = $urandom_range(0, 1) == 1;
          c_adr   = 32'($urandom_range(0, 63)) << 2;
          c_wdata = $urandom;
        end
        if (!l_req || m_gl) begin
          l_req   = ($urandom_range(0, 2) != 0);
          l_we    = $urandom_range(0, 1) == 1;
          l_adr   = 32'($urandom_range(0, 63)) << 2;
          l_wdata = $urandom;
        end
        l_lock = ($urandom_range(0, 99) < lock_pct);
        cycle();
      end
    end
    rst = 0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
